mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Multi-cycle multiply/divide unit in the EX stage, beside the ALU. It is fed the same forwarded dataA/dataB operands and funct code that drive the ALU.
- MULT, MULTU, DIV and DIVU write the architectural HI/LO registers after a fixed iterative latency.
- MFHI and MFLO read HI/LO onto dataOut, which the EX result mux selects in place of the ALU result.
- The busy output feeds hazard detection, which stalls IF/ID/EX while an operation is in flight.

Parameters:
DATA_W, 32, operand/HI/LO width. Iteration count equals DATA_W.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
start  input  1  operation request, qualified with funct
funct  input  6  MIPS funct field: MULT=24, MULTU=25, DIV=26, DIVU=27, MFHI=16, MFLO=18
dataA  input  DATA_W  rs operand (multiplicand/dividend)
dataB  input  DATA_W  rt operand (multiplier/divisor)
busy  output  1  operation in progress; pipeline must stall
done  output  1  one-cycle pulse when HI/LO are updated
hi  output  DATA_W  HI register
lo  output  DATA_W  LO register
dataOut  output  DATA_W  combinational: hi if funct==MFHI, lo if funct==MFLO, else 0

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; hi=lo=0; busy=0; done=0; internal counter, accumulator and operand registers cleared.
  - Reset mid-operation aborts the operation; HI/LO are not updated with partial results.
- FSM states IDLE, MUL, DIV, FIN.
- IDLE:
  - start=1 with funct in {24,25,26,27} latches the operands and goes to MUL (24,25) or DIV (26,27). Counter=0 and busy=1 from the next cycle.
  - start with any other funct (including MFHI/MFLO) is ignored.
- Signed ops (MULT, DIV): latch |dataA| and |dataB|. Record result sign sA^sB and remainder sign sA.
- MUL: shift-add, 1 multiplier bit per cycle, 2*DATA_W-bit product accumulator. After DATA_W cycles go to FIN.
- DIV: restoring division, 1 quotient bit per cycle, DATA_W+1-bit partial remainder. After DATA_W cycles go to FIN.
- FIN:
  - Apply sign correction (two's-complement negate of product, quotient and remainder as required).
  - Write hi/lo:
    - MUL: hi=product[63:32], lo=product[31:0].
    - DIV: lo=quotient, hi=remainder.
  - done=1 for this cycle only; busy=0 this cycle; next state IDLE.
- Latency: start sampled at edge T gives busy high for cycles T+1..T+DATA_W, and done=1 with new hi/lo visible at cycle T+DATA_W+1. That is 33 cycles for DATA_W=32.
- start while busy (MUL/DIV/FIN) is ignored; no queueing.
- start in the same cycle done is asserted is ignored; it is accepted only from IDLE.
- Divide by zero (dataB==0):
  - DIV/DIVU still runs the full latency and no exception is raised.
  - Result: hi=dataA as latched (original signed value), lo=32'hFFFFFFFF.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. All other results are exact modulo 2^32 per half.
- hi/lo hold their values between operations. MFHI/MFLO during busy return the old values; stalling is the hazard unit's job.
- dataOut is purely combinational from funct and the hi/lo registers.

Decomposition:
- Shared package mips_pkg:
  - funct constants FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO.
  - The existing ALU funct codes (AND=36, OR=37, ADD=32, SUB=34, SLT=42), so ALU and this unit decode from one source.
  - FSM state encoding type.
- One sub-module: md_sign_fix, a combinational conditional two's-complement negate used for operand absolute value and result correction, instanced for the 64-bit product and the two 32-bit div results.

Test Plan:
- Reset low for 2 cycles, then high -> hi=lo=0, busy=0, done=0; dataOut=0 for funct=MFHI.
- MULTU dataA=0xFFFFFFFF dataB=0xFFFFFFFF, start 1 cycle -> busy high 32 cycles, done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT dataA=-3 (0xFFFFFFFD) dataB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then funct=MFLO -> dataOut=0xFFFFFFEB.
- DIVU 100/7 -> lo=0x0000000E, hi=0x00000002. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 5/0 -> done after 33 cycles, lo=0xFFFFFFFF, hi=0x00000005. Second start issued at cycle 10 of that op -> ignored, no extra done pulse.
- Start MULT 6*7, pull reset low at cycle 15 -> next cycle busy=0, hi=lo=0, no done pulse. New MULTU 6*7 after reset -> lo=42, hi=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants for the EX stage (ALU and multiply/divide unit)
// plus the multiply/divide sequencer state type.
package mips_pkg;

    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate: absolute value of operands on the way in,
// sign restoration of product/quotient/remainder on the way out.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, results written to HI/LO as the last iteration completes.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] dataA,
    input  logic [DATA_W-1:0] dataB,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] dataOut
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    md_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic [2*DATA_W-1:0]   r_prod;
    logic [DATA_W-1:0]     r_rem;
    logic [DATA_W-1:0]     r_quo;
    logic [DATA_W-1:0]     r_opb;
    logic                  r_neg_res;
    logic                  r_neg_rem;
    logic                  r_dvz;

    logic                  w_is_mul;
    logic                  w_is_div;
    logic                  w_is_signed;
    logic                  w_last;
    logic [DATA_W-1:0]     w_abs_a;
    logic [DATA_W-1:0]     w_abs_b;
    logic [DATA_W:0]       w_mul_sum;
    logic [2*DATA_W-1:0]   w_prod_next;
    logic [DATA_W:0]       w_div_shift;
    logic [DATA_W-1:0]     w_div_diff;
    logic                  w_div_ge;
    logic [DATA_W-1:0]     w_rem_next;
    logic [DATA_W-1:0]     w_quo_next;
    logic [2*DATA_W-1:0]   w_prod_fix;
    logic [DATA_W-1:0]     w_quo_fix;
    logic [DATA_W-1:0]     w_rem_fix;

    assign w_is_mul    = (funct == FN_MULT) || (funct == FN_MULTU);
    assign w_is_div    = (funct == FN_DIV)  || (funct == FN_DIVU);
    assign w_is_signed = (funct == FN_MULT) || (funct == FN_DIV);
    assign w_last      = (r_cnt == CNT_W'(DATA_W - 1));

    md_sign_fix #(.W(DATA_W)) u_abs_a (
        .i_val (dataA),
        .i_neg (w_is_signed & dataA[DATA_W-1]),
        .o_val (w_abs_a)
    );

    md_sign_fix #(.W(DATA_W)) u_abs_b (
        .i_val (dataB),
        .i_neg (w_is_signed & dataB[DATA_W-1]),
        .o_val (w_abs_b)
    );

    // Multiplier sits in the low half of the accumulator and is consumed LSB first.
    assign w_mul_sum   = {1'b0, r_prod[2*DATA_W-1:DATA_W]} + (r_prod[0] ? {1'b0, r_opb} : '0);
    assign w_prod_next = {w_mul_sum, r_prod[DATA_W-1:1]};

    // The DATA_W+1-bit partial remainder is the shifted value; the kept
    // remainder is always below the divisor so DATA_W bits suffice in storage.
    assign w_div_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_div_diff  = w_div_shift[DATA_W-1:0] - r_opb;
    assign w_rem_next  = w_div_ge ? w_div_diff : w_div_shift[DATA_W-1:0];
    assign w_quo_next  = {r_quo[DATA_W-2:0], w_div_ge};

    md_sign_fix #(.W(2*DATA_W)) u_fix_prod (
        .i_val (w_prod_next),
        .i_neg (r_neg_res),
        .o_val (w_prod_fix)
    );

    md_sign_fix #(.W(DATA_W)) u_fix_quo (
        .i_val (w_quo_next),
        .i_neg (r_neg_res),
        .o_val (w_quo_fix)
    );

    md_sign_fix #(.W(DATA_W)) u_fix_rem (
        .i_val (w_rem_next),
        .i_neg (r_neg_rem),
        .o_val (w_rem_fix)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_opb     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dvz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && (w_is_mul || w_is_div)) begin
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_neg_res <= w_is_signed & (dataA[DATA_W-1] ^ dataB[DATA_W-1]);
                        r_neg_rem <= w_is_signed & dataA[DATA_W-1];
                        r_dvz     <= (dataB == '0);
                        if (w_is_mul) begin
                            r_prod  <= {{DATA_W{1'b0}}, w_abs_b};
                            r_opb   <= w_abs_a;
                            r_state <= ST_MUL;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_abs_a;
                            r_opb   <= w_abs_b;
                            r_state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    r_prod <= w_prod_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi    <= w_prod_fix[2*DATA_W-1:DATA_W];
                        r_lo    <= w_prod_fix[DATA_W-1:0];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_FIN;
                    end
                end
                ST_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // Divide by zero leaves the dividend as remainder naturally; only LO is forced.
                        r_hi    <= w_rem_fix;
                        r_lo    <= r_dvz ? '1 : w_quo_fix;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dataOut = '0;
        if (funct == FN_MFHI) begin
            dataOut = r_hi;
        end else if (funct == FN_MFLO) begin
            dataOut = r_lo;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of MUL/DIV vectors with hand-computed
// HI/LO, plus sequences for ignored starts and mid-operation reset.
module tb_mult_div_unit;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] dataOut;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_unit #(.DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct   (funct),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op; optionally re-assert start on the given cycle of the op.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, output int lat, output int nbusy, output logic busy_at_done);
        @(negedge clk);
        funct = f;
        dataA = a;
        dataB = b;
        start = 1'b1;
        lat   = 0;
        nbusy = 0;
        busy_at_done = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            start = (inj_at != 0 && lat == inj_at);
            if (inj_at != 0 && lat == inj_at) begin
                dataA = 32'd9;
                dataB = 32'd3;
            end
            if (busy) nbusy++;
        end while (!done && lat < 40);
        busy_at_done = busy;
    endtask

    task automatic check_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                            input int inj_at);
        int   lat;
        int   nbusy;
        logic bad;
        run_op(f, a, b, inj_at, lat, nbusy, bad);
        $display("%s: funct=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d", tag, f, a, b, hi, lo, lat);
        chk({tag, " latency"}, 32'(lat), 32'd33);
        chk({tag, " busy cycles"}, 32'(nbusy), 32'd32);
        chk({tag, " busy at done"}, {31'd0, bad}, 32'd0);
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done width"}, {31'd0, done}, 32'd0);
        chk({tag, " idle after"}, {31'd0, busy}, 32'd0);
        funct = FN_MFHI;
        #1;
        chk({tag, " MFHI"}, dataOut, eh);
        funct = FN_MFLO;
        #1;
        chk({tag, " MFLO"}, dataOut, el);
        funct = FN_ADD;
        #1;
        chk({tag, " dataOut other"}, dataOut, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dones;
        int   cyc;

        vecs[0]  = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{FN_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{FN_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[3]  = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6]  = '{FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{FN_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[8]  = '{FN_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[9]  = '{FN_MULT,  32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[10] = '{FN_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

        reset = 1'b0;
        start = 1'b0;
        funct = FN_MFHI;
        dataA = '0;
        dataB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset dataOut MFHI", dataOut, 32'd0);

        // MFHI/MFLO starts must be ignored.
        @(negedge clk);
        funct = FN_MFLO;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("ignored start funct=MFLO -> busy=%0b", busy);
        chk("MFLO start ignored", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                     vecs[i].exp_hi, vecs[i].exp_lo, 0);
        end

        // Divide by zero with a second start mid-flight: must not be queued.
        check_op("dvz+start@10", FN_DIVU, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 10);
        dones = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("no extra op after dvz", 32'(dones), 32'd0);

        // Start coinciding with the done cycle must be ignored.
        check_op("start@done", FN_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 33);
        dones = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("no op from done-cycle start", 32'(dones), 32'd0);

        // Reset mid-operation aborts without writing HI/LO.
        @(negedge clk);
        funct = FN_MULT;
        dataA = 32'd6;
        dataB = 32'd7;
        start = 1'b1;
        for (cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        $display("abort: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        reset = 1'b1;
        dones = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort no done", 32'(dones), 32'd0);
        check_op("post-reset", FN_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
